// File: rtl/square_root_encoder.sv
// Purpose: iterative integer square root; one root bit per clock, MSB pair first.
// Latency: done pulses in the cycle after edge N+ROOT_W when start is accepted on edge N.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); requests during CALC are dropped.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      request, sampled while busy=0
//   sq_in      operand, captured on the accepting edge
//   root       floor(sqrt(sq_in))
//   rem        sq_in - root*root
//   exact      rem == 0
//   busy       iterating
//   done       one-cycle result-valid pulse
module square_root_encoder #(
   parameter int WIDTH  = 8,
   parameter int ROOT_W = WIDTH / 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  sq_in,
   output logic [ROOT_W-1:0] root,
   output logic [ROOT_W:0]   rem,
   output logic              exact,
   output logic              busy,
   output logic              done
);

   // The partial remainder is two bits wider than the root so the shifted
   // trial value can never wrap before the compare.
   localparam int RW    = ROOT_W + 2;
   localparam int CNT_W = $clog2(ROOT_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   op_q,     op_d;
   logic [ROOT_W-1:0]  proot_q,  proot_d;
   logic [RW-1:0]      prem_q,   prem_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [ROOT_W-1:0]  root_q,   root_d;
   logic [ROOT_W:0]    rem_q,    rem_d;
   logic               exact_q,  exact_d;

   logic [1:0]         pair;
   logic [RW-1:0]      trial;
   logic [RW-1:0]      test;
   logic               take;
   logic [RW-1:0]      rem_step;
   logic [ROOT_W-1:0]  root_step;

   // One restoring step on the current top bit pair of the operand.
   always_comb begin
      pair      = op_q[WIDTH-1 -: 2];
      trial     = (prem_q << 2) | RW'(pair);
      test      = {proot_q, 2'b01};
      take      = (trial >= test);
      rem_step  = take ? (trial - test) : trial;
      root_step = (proot_q << 1) | ROOT_W'(take);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      proot_d = proot_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      root_d  = root_q;
      rem_d   = rem_q;
      exact_d = exact_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               op_d    = sq_in;
               proot_d = '0;
               prem_d  = '0;
               cnt_d   = CNT_W'(ROOT_W);
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            op_d    = op_q << 2;
            proot_d = root_step;
            prem_d  = rem_step;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Final remainder is bounded by 2*root, so ROOT_W+1 bits hold it.
               root_d  = root_step;
               rem_d   = rem_step[ROOT_W:0];
               exact_d = (rem_step == '0);
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         proot_q <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         exact_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         proot_q <= proot_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         exact_q <= exact_d;
      end
   end

   assign root  = root_q;
   assign rem   = rem_q;
   assign exact = exact_q;
   assign busy  = (state_q == S_CALC);
   assign done  = (state_q == S_DONE);

endmodule

// File: doc/square_root_encoder.md
Name: square_root_encoder

Overview:
- Inverse of the team's combinational squaring decoder, which maps a 4-bit value to its 8-bit square.
- This block takes an 8-bit (WIDTH) operand and iteratively computes its integer square root floor(sqrt(x)), the remainder and a perfect-square flag.
- It resolves one root bit per clock using the restoring digit-by-digit method, with a start/busy/done handshake.
- It sits downstream of the squarer so squared codes can be mapped back to 4-bit indices, and it serves as the self-check partner in decoder benches.

Parameters:
- WIDTH, 8: operand width in bits; must be even and >= 2.
- ROOT_W, WIDTH/2: root width and iteration count. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sq_in  input  WIDTH  operand; captured on the edge that accepts start
- root  output  ROOT_W  floor(sqrt(sq_in))
- rem  output  ROOT_W+1  sq_in - root*root; range 0..2*root
- exact  output  1  1 when rem==0
- busy  output  1  1 while iterating
- done  output  1  one-cycle pulse; results valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: on an edge with rst=1, state goes to IDLE and root=0, rem=0, exact=0, busy=0, done=0. rst has priority over start and aborts any computation in flight; no done is produced for the aborted operand.
- States:
  - IDLE: busy=0, done=0. start=1 captures sq_in into the operand shift register, clears the partial root and remainder, sets count=ROOT_W, and moves to CALC.
  - CALC: busy=1. Each edge processes one bit pair, MSB pair first:
    - trial = (partial_rem << 2) | next_pair
    - test = (partial_root << 2) | 1
    - if trial >= test: partial_rem = trial - test and the root bit is 1; otherwise partial_rem = trial and the root bit is 0.
    - partial_root shifts left by 1, taking the new root bit in.
    - count decrements. The edge where count goes 1->0 loads root, rem and exact and moves to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 in this cycle is accepted as in IDLE (back-to-back operation) and goes to CALC; otherwise the next state is IDLE.
- Latency: if start is accepted on edge N, done is high in the cycle after edge N+ROOT_W. For WIDTH=8 that is N+4. Sustained throughput is one result per ROOT_W+1 cycles.
- start while busy=1 is ignored. Changes on sq_in after capture have no effect.
- root, rem and exact change only on the edge entering DONE or on reset, and are held stable otherwise, including through later CALC cycles until the next result loads.
- Widths: the internal remainder register is ROOT_W+2 bits so the trial compare cannot overflow. rem is reported truncated to ROOT_W+1 bits, which is lossless because rem <= 2*root <= 2^(ROOT_W+1)-2.
- Boundaries, WIDTH=8:
  - sq_in=0: root=0, rem=0, exact=1.
  - sq_in=255: root=15, rem=30, exact=0.
  - The maximum root is 2^ROOT_W-1; there is no overflow case.

Test Plan:
- Reset, then start with sq_in=225 at edge N -> busy=1 in the cycles after edges N..N+3; done=1 only after edge N+4; root=15, rem=0, exact=1.
- Sweep sq_in=0..255 back-to-back, reasserting start in each DONE cycle -> every result satisfies root*root+rem==sq_in and rem<=2*root. Spot checks: 0 gives 0/0/1, 200 gives 14/4/0, 255 gives 15/30/0. Exactly one done pulse per operand, with done spaced 5 cycles apart.
- Start with 144, then pulse start with 9 during CALC -> second request ignored; result is 12/0/1 and a single done.
- Start with 100, change sq_in to 50 one cycle after acceptance -> result is 10/0/1.
- Start with 200, assert rst on the second CALC cycle -> next cycle state is IDLE, all outputs 0, and no done follows. A subsequent start with 16 gives 4/0/1 with normal latency.
- Loopback with the squaring decoder: feed each 4-bit k through the squarer into this block -> root==k, rem==0, exact=1 for all k=0..15.
